inport_uart_rx: RTL and testbench

//   Serial front-end for the Mini SRC input port. Receives 8N1 UART bytes on a single pin.

---
 rtl/minisrc_io_pkg.sv | 16 +
 rtl/sync_ff.sv | 26 ++
 rtl/inport_uart_rx.sv | 217 +++++++++++++++++++++
 tb/tb_inport_uart_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_io_pkg.sv
// Shared types and constants for the Mini SRC serial input port.
package minisrc_io_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int INPORT_BYTES   = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous serial line; resets to the idle (high) level.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else if (clr) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/inport_uart_rx.sv
// UART receiver that packs four bytes (little-endian) into a held 32-bit InPort word.
// Define INPORT_UART_PARITY_EN for 8E1 frames with a sticky par_err output; default is 8N1.
module inport_uart_rx
  import minisrc_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              rx,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic [1:0]        byte_idx,
  output logic              busy,
  output logic              frame_err,
`ifdef INPORT_UART_PARITY_EN
  output logic              par_err,
`endif
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int ASM_W = WORD_W - UART_DATA_BITS;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [ASM_W-1:0]          asm_q, asm_d;
  logic [1:0]                idx_q, idx_d;
  logic [WORD_W-1:0]         word_q, word_d;
  logic                      valid_q, valid_d;
  logic                      good_q, good_d;
  logic                      ferr_q, ferr_d;
  logic                      rx_prev_q, rx_prev_d;
  logic                      rx_s;
  logic                      par_ok;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .d       (rx),
    .q       (rx_s)
  );

`ifdef INPORT_UART_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic perr_q, perr_d;
  // Even parity: the received parity bit must equal the XOR of the data bits.
  assign par_ok = (par_bit_q == ^shift_q);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      asm_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      good_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_prev_q <= 1'b1;
`ifdef INPORT_UART_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      asm_q     <= asm_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      good_q    <= good_d;
      ferr_q    <= ferr_d;
      rx_prev_q <= rx_prev_d;
`ifdef INPORT_UART_PARITY_EN
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    asm_d     = asm_q;
    idx_d     = idx_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    good_d    = 1'b0;
    ferr_d    = ferr_q;
    rx_prev_d = rx_s;
`ifdef INPORT_UART_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
    if (err_clr) perr_d = 1'b0;
`endif
    if (err_clr) ferr_d = 1'b0;

    // A good byte is committed one clock after its stop-bit sample; shift_q is stable by then.
    if (good_q) begin
      if (idx_q == 2'(INPORT_BYTES - 1)) begin
        word_d  = {shift_q, asm_q};
        valid_d = 1'b1;
        idx_d   = '0;
      end else begin
        for (int i = 0; i < INPORT_BYTES - 1; i++) begin
          if (idx_q == 2'(i)) asm_d[i*UART_DATA_BITS +: UART_DATA_BITS] = shift_q;
        end
        idx_d = idx_q + 2'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef INPORT_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef INPORT_UART_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) ferr_d = 1'b1;
`ifdef INPORT_UART_PARITY_EN
          if (!par_ok) perr_d = 1'b1;
`endif
          if (rx_s && par_ok) good_d = 1'b1;
          else                idx_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      bit_cnt_d = '0;
      shift_d   = '0;
      asm_d     = '0;
      idx_d     = '0;
      word_d    = '0;
      valid_d   = 1'b0;
      good_d    = 1'b0;
      ferr_d    = 1'b0;
      rx_prev_d = 1'b1;
`ifdef INPORT_UART_PARITY_EN
      par_bit_d = 1'b0;
      perr_d    = 1'b0;
`endif
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign byte_idx   = idx_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = ferr_q;
`ifdef INPORT_UART_PARITY_EN
  assign par_err    = perr_q;
`endif

endmodule

// File: tb/tb_inport_uart_rx.sv
// Directed self-checking bench for inport_uart_rx (CLKS_PER_BIT = 8).
module tb_inport_uart_rx;

  localparam int CPB = 8;
`ifdef INPORT_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Edge (counted from the start-bit negedge) on which a completed word is committed.
  localparam int DONE_EDGE = 4 + CPB / 2 + CPB * (FRAME_BITS - 1);

  logic        clk;
  logic        reset_n;
  logic        clr;
  logic        rx;
  logic        err_clr;
  logic [31:0] word_out;
  logic        word_valid;
  logic [1:0]  byte_idx;
  logic        busy;
  logic        frame_err;
`ifdef INPORT_UART_PARITY_EN
  logic        par_err;
`endif

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  logic [31:0] last_word = '0;

  inport_uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .rx         (rx),
    .word_out   (word_out),
    .word_valid (word_valid),
    .byte_idx   (byte_idx),
    .busy       (busy),
    .frame_err  (frame_err),
`ifdef INPORT_UART_PARITY_EN
    .par_err    (par_err),
`endif
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_valid) begin
      valid_cnt++;
      last_word = word_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("check %s = %08h ok", tag, got);
    end
  endtask

  // Drives one frame starting at the current negedge, then a short idle gap.
  task automatic send_byte(input logic [7:0] d, input logic stop_ok, input logic par_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef INPORT_UART_PARITY_EN
    rx = par_ok ? ^d : ~(^d);
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    $display("frame %02h stop_ok %0d par_ok %0d byte_idx %0d", d, stop_ok, par_ok, byte_idx);
  endtask

  initial begin
    reset_n = 1'b0;
    clr     = 1'b0;
    rx      = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_word", word_out, 32'h0);
    check("rst_valid", {31'b0, word_valid}, 32'h0);
    check("rst_idx", {30'b0, byte_idx}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_ferr", {31'b0, frame_err}, 32'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Four good bytes assemble little-endian.
    send_byte(8'h78, 1'b1, 1'b1);
    check("t1_idx1", {30'b0, byte_idx}, 32'd1);
    send_byte(8'h56, 1'b1, 1'b1);
    check("t1_idx2", {30'b0, byte_idx}, 32'd2);
    send_byte(8'h34, 1'b1, 1'b1);
    check("t1_idx3", {30'b0, byte_idx}, 32'd3);
    check("t1_partial_hidden", word_out, 32'h0);
    send_byte(8'h12, 1'b1, 1'b1);
    check("t1_idx0", {30'b0, byte_idx}, 32'd0);
    check("t1_word", word_out, 32'h12345678);
    check("t1_valid_cnt", valid_cnt, 32'd1);
    check("t1_valid_word", last_word, 32'h12345678);

    // Short low glitch is rejected at the half-bit sample.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_busy_in_start", {31'b0, busy}, 32'd1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t2_busy", {31'b0, busy}, 32'd0);
    check("t2_ferr", {31'b0, frame_err}, 32'd0);
    check("t2_idx", {30'b0, byte_idx}, 32'd0);
    check("t2_word", word_out, 32'h12345678);
    check("t2_valid_cnt", valid_cnt, 32'd1);

    // Framing error discards the partial word.
    send_byte(8'hAA, 1'b1, 1'b1);
    check("t3_idx_after_aa", {30'b0, byte_idx}, 32'd1);
    send_byte(8'hBB, 1'b0, 1'b1);
    check("t3_ferr", {31'b0, frame_err}, 32'd1);
    check("t3_idx_resync", {30'b0, byte_idx}, 32'd0);
    send_byte(8'h11, 1'b1, 1'b1);
    send_byte(8'h22, 1'b1, 1'b1);
    send_byte(8'h33, 1'b1, 1'b1);
    send_byte(8'h44, 1'b1, 1'b1);
    check("t3_word", word_out, 32'h44332211);
    check("t3_valid_cnt", valid_cnt, 32'd2);
    check("t3_ferr_sticky", {31'b0, frame_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t3_ferr_cleared", {31'b0, frame_err}, 32'd0);

    // clr coincides with the commit edge of the fourth byte.
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h02, 1'b1, 1'b1);
    send_byte(8'h03, 1'b1, 1'b1);
    fork
      send_byte(8'h04, 1'b1, 1'b1);
      begin
        repeat (DONE_EDGE - 1) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
    join
    check("t4_word", word_out, 32'h0);
    check("t4_idx", {30'b0, byte_idx}, 32'd0);
    check("t4_valid_cnt", valid_cnt, 32'd2);

    // Asynchronous reset mid-byte loses the partial word.
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h02, 1'b1, 1'b1);
    check("t5_idx_before", {30'b0, byte_idx}, 32'd2);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5_idx_in_reset", {30'b0, byte_idx}, 32'd0);
    check("t5_busy_in_reset", {31'b0, busy}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'hDE, 1'b1, 1'b1);
    send_byte(8'hAD, 1'b1, 1'b1);
    send_byte(8'hBE, 1'b1, 1'b1);
    send_byte(8'hEF, 1'b1, 1'b1);
    check("t5_valid_cnt", valid_cnt, 32'd3);
    check("t5_valid_word", last_word, 32'hEFBEADDE);
    check("t5_word", word_out, 32'hEFBEADDE);

`ifdef INPORT_UART_PARITY_EN
    // Parity mismatch discards the byte and sets par_err only.
    send_byte(8'h55, 1'b1, 1'b1);
    check("t6_idx_good", {30'b0, byte_idx}, 32'd1);
    send_byte(8'h07, 1'b1, 1'b0);
    check("t6_perr", {31'b0, par_err}, 32'd1);
    check("t6_idx", {30'b0, byte_idx}, 32'd0);
    check("t6_ferr", {31'b0, frame_err}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t6_perr_cleared", {31'b0, par_err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
